// File: rtl/spi_pkt_ctrl.sv
// SPI packet controller: frames command/data bytes from an SPI byte shifter
// into single-cycle register read/write strobes, with abort and timeout handling.
module spi_pkt_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              byte_flg,
    input  logic [7:0]        spi_byte,
    output logic              spi_en,
    output logic              spi_clr,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               rw_r, rw_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [7:0]         wdata_s;
    logic               clr_s, wr_s, rd_s, done_s, err_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state, timeout counter and next values of every registered output
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rw_s    = rw_r;
        addr_s  = reg_addr;
        wdata_s = reg_wdata;
        clr_s   = 1'b0;
        wr_s    = 1'b0;
        rd_s    = 1'b0;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_s = '0;
                if (!cs_n) begin
                    clr_s   = 1'b1;
                    state_s = S_CMD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CMD: begin
                // A byte wins over both abort and timeout in the same cycle
                if (byte_flg) begin
                    cnt_s  = '0;
                    rw_s   = spi_byte[7];
                    addr_s = spi_byte[ADDR_W-1:0];
                    if (spi_byte[7]) begin
                        rd_s    = 1'b1;
                        done_s  = 1'b1;
                        state_s = S_HOLD;
                    end else begin
                        state_s = S_DATA;
                    end
                end else if (cs_n) begin
                    err_s   = 1'b1;
                    state_s = S_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    err_s   = 1'b1;
                    state_s = S_ERR;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            S_DATA: begin
                if (byte_flg) begin
                    cnt_s   = '0;
                    wdata_s = spi_byte;
                    wr_s    = 1'b1;
                    done_s  = 1'b1;
                    state_s = S_HOLD;
                end else if (cs_n) begin
                    err_s   = 1'b1;
                    state_s = S_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    err_s   = 1'b1;
                    state_s = S_ERR;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            S_HOLD, S_ERR: begin
                if (cs_n) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter and output registers; reset clears everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            rw_r      <= 1'b0;
            spi_en    <= 1'b0;
            spi_clr   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rw_r      <= rw_s;
            spi_en    <= (state_s == S_CMD) || (state_s == S_DATA);
            spi_clr   <= clr_s;
            reg_wr    <= wr_s;
            reg_rd    <= rd_s;
            reg_addr  <= addr_s;
            reg_wdata <= wdata_s;
            pkt_done  <= done_s;
            pkt_err   <= err_s;
            busy      <= (state_s != S_IDLE);
        end
    end

endmodule

// File: doc/spi_pkt_ctrl.md
SPI_PKT_CTRL -- requirements
Module: spi_pkt_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7: width of register address carried in the command byte; 1..7.
REQ-002 Parameter TIMEOUT, default 64: maximum clk cycles allowed between byte_flg pulses inside a packet; at least 2.
REQ-003 clk  input  1  the single clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 cs_n  input  1  packet frame select, active-low, synchronous to clk.
REQ-006 byte_flg  input  1  one-cycle pulse from the SPI byte shifter; spi_byte is valid in the same cycle.
REQ-007 spi_byte  input  8  assembled byte from the shifter (SPI_in).
REQ-008 spi_en  output  1  shift enable to the shifter (en).
REQ-009 spi_clr  output  1  one-cycle clear pulse to the shifter bit counter, asserted at packet start.
REQ-010 reg_wr  output  1  register write strobe, one cycle.
REQ-011 reg_rd  output  1  register read strobe, one cycle.
REQ-012 reg_addr  output  ADDR_W  latched register address.
REQ-013 reg_wdata  output  8  write data, valid while reg_wr=1.
REQ-014 pkt_done  output  1  one-cycle pulse, packet completed.
REQ-015 pkt_err  output  1  one-cycle pulse, packet aborted or timed out.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, CMD, DATA, HOLD, ERR; all outputs registered.
REQ-018 IDLE: spi_en=0; on cs_n=0, pulse spi_clr for one cycle and go to CMD.
REQ-019 CMD and DATA: spi_en=1; all other states: spi_en=0.
REQ-020 CMD on byte_flg: latch rw=spi_byte[7] and reg_addr=spi_byte[ADDR_W-1:0].
REQ-021 CMD on byte_flg with rw=1: assert reg_rd and pkt_done in the next cycle, then go to HOLD.
REQ-022 CMD on byte_flg with rw=0: go to DATA.
REQ-023 DATA on byte_flg: in the next cycle, assert reg_wr and pkt_done with reg_wdata=spi_byte, then go to HOLD.
REQ-024 HOLD: ignore byte_flg; on cs_n=1, go to IDLE.
REQ-025 cs_n=1 in CMD or DATA without byte_flg: pulse pkt_err next cycle, no reg_rd/reg_wr, go to IDLE.
REQ-026 byte_flg and cs_n=1 in the same cycle: the byte is accepted per REQ-021/023, then HOLD exits to IDLE on the following cycle.
REQ-027 Timeout counter: cleared on entry to CMD, entry to DATA, and every byte_flg; increments each cycle in CMD/DATA; saturates.
REQ-028 Counter reaching TIMEOUT-1 without byte_flg: pulse pkt_err next cycle and go to ERR.
REQ-029 byte_flg in the same cycle as the timeout takes priority over the timeout.
REQ-030 ERR: spi_en=0; wait for cs_n=1, then go to IDLE.
REQ-031 reg_addr and reg_wdata hold their last values between strobes.
REQ-032 reg_wr, reg_rd, pkt_done, pkt_err and spi_clr are never high for more than one consecutive cycle.
REQ-033 reg_wr and reg_rd are mutually exclusive; pkt_done and pkt_err are mutually exclusive.

Reset
REQ-034 rst=0 immediately forces state IDLE, timeout counter 0, rw 0, and every output 0, including reg_addr and reg_wdata.
REQ-035 Reset asserted mid-packet discards the packet; no strobe or pkt_err is issued for it.
REQ-036 After rst rises with cs_n=0, the controller starts a packet per REQ-018.

Verification
REQ-037 Write packet: cs_n=0, byte_flg with 0x15, later byte_flg with 0xA5 -> one cycle after the second byte, reg_wr=1, reg_addr=0x15, reg_wdata=0xA5, pkt_done=1; spi_en=0 thereafter.
REQ-038 Read packet: byte_flg with 0x83 -> next cycle reg_rd=1, reg_addr=0x03, pkt_done=1, reg_wr stays 0; IDLE after cs_n=1.
REQ-039 Abort: command 0x15 accepted, then cs_n=1 before the data byte -> pkt_err=1 for one cycle, no reg_wr, busy=0 on the following cycle.
REQ-040 Timeout: cs_n=0, no byte_flg for 64 cycles -> pkt_err pulses, spi_en=0 and busy=1 until cs_n=1.
REQ-041 Reset mid-DATA: rst=0 -> all outputs 0 asynchronously, no reg_wr for the partial packet.
REQ-042 Simultaneous data byte_flg (0x3C) and cs_n=1 -> reg_wr=1 with reg_wdata=0x3C, no pkt_err, IDLE two cycles later.
